ec_conv_enc_param: RTL

- Parametrised word-level convolutional encoder for the EC send path. Accepts DATA_W-bit words over a valid/ack handshake and serialises them MSB first.
- Encodes each bit with a rate-1/2 code of configurable constraint length and generator polynomials. Appends optional zero-tail termination.
- Packs the coded symbols MSB first into OUT_W-bit output words. Feeds the QPSK modulator directly, as one block replacing the separate slice/convolution/collect chain.

---
 rtl/ec_conv_enc_param.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ec_conv_enc_param.sv
// rtl/ec_conv_enc_param.sv - word-level rate-1/2 convolutional encoder with MSB-first symbol packing
// Optional rate-2/3 puncturing is built in when EC_CONV_PUNCT_EN is defined.
module ec_conv_enc_param #(
  parameter int             DATA_W    = 32,
  parameter int             OUT_W     = 32,
  parameter int             K         = 3,
  parameter logic [K-1:0]   G0        = 3'b111,
  parameter logic [K-1:0]   G1        = 3'b101,
  parameter bit             TERMINATE = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              punct_i,
  output logic              ack_i,
  output logic              valid_o,
  output logic [OUT_W-1:0]  data_o,
  output logic              busy_o
);
  localparam int BW = $clog2(DATA_W + K);
  localparam int CW = $clog2(OUT_W + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_TAIL = BW'(K - 2);
  localparam logic [CW:0]   OUT_FULL  = (CW+1)'(OUT_W);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, PAD} state_t;

  state_t            state;
  logic [DATA_W-1:0] word;
  logic [BW-1:0]     bit_cnt;
  logic [K-2:0]      sr;
  logic [OUT_W-1:0]  pack;
  logic [CW-1:0]     pack_cnt;

  logic              b, c0, c1, drop;
  logic [K-1:0]      taps;
  logic [OUT_W+1:0]  merged;
  logic [CW:0]       fill;

  assign ack_i  = valid_i & (state == IDLE);
  assign busy_o = (state != IDLE);
  assign b      = (state == DATA) ? word[DATA_W-1] : 1'b0;
  assign taps   = {b, sr};
  assign c0     = ^(G0 & taps);
  assign c1     = ^(G1 & taps);

`ifdef EC_CONV_PUNCT_EN
  logic punct;
  logic odd_bit;
  assign drop = punct & odd_bit;
`else
  logic unused_punct;
  assign unused_punct = punct_i;
  assign drop         = 1'b0;
`endif

  // Two spare low bits catch the overflow symbol when only one slot is free.
  assign merged = {pack, 2'b00}
                | ({{OUT_W{1'b0}}, c0, c1 & ~drop} << (OUT_W - int'(pack_cnt)));
  assign fill   = {1'b0, pack_cnt} + (drop ? (CW+1)'(1) : (CW+1)'(2));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      word     <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      pack     <= '0;
      pack_cnt <= '0;
      valid_o  <= 1'b0;
      data_o   <= '0;
`ifdef EC_CONV_PUNCT_EN
      punct    <= 1'b0;
      odd_bit  <= 1'b0;
`endif
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            word    <= data_i;
            bit_cnt <= '0;
            state   <= DATA;
`ifdef EC_CONV_PUNCT_EN
            punct   <= punct_i;
            odd_bit <= 1'b0;
`endif
          end
        end
        DATA, TAIL: begin
          word <= {word[DATA_W-2:0], 1'b0};
          sr   <= taps[K-1:1];
`ifdef EC_CONV_PUNCT_EN
          odd_bit <= ~odd_bit;
`endif
          if (fill >= OUT_FULL) begin
            valid_o  <= 1'b1;
            data_o   <= merged[OUT_W+1:2];
            pack     <= {merged[1:0], {(OUT_W-2){1'b0}}};
            pack_cnt <= CW'(fill - OUT_FULL);
          end else begin
            pack     <= merged[OUT_W+1:2];
            pack_cnt <= fill[CW-1:0];
          end
          if (state == DATA) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= TERMINATE ? TAIL : PAD;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else if (bit_cnt == LAST_TAIL) begin
            state <= PAD;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        PAD: begin
          if (pack_cnt != '0) begin
            valid_o <= 1'b1;
            data_o  <= pack;
          end
          pack     <= '0;
          pack_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
